ram_arb: RTL and testbench

RAM_ARB -- requirements
Module: ram_arb

---
 rtl/ram_arb.sv | 170 +++++++++++++++++
 tb/tb_ram_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb.sv
// ram_arb: two-requester arbiter in front of one single-port RAM.
//   The IFU (instruction fetch) issues reads only. The LSU (load/store) issues
//   reads and byte-masked writes. A single transaction is outstanding at a
//   time, sequenced IDLE -> BUSY -> RESP.
//   The LSU wins a simultaneous request until it has been granted
//   STARVE_LIMIT times in a row while the IFU was waiting. The next tie then
//   goes to the IFU.
// Ports:
//   i_sys_clk, i_sys_rst       clock, asynchronous active-high reset
//   i_ifu_*/o_ifu_*            IFU read request, grant, and response
//   i_lsu_*/o_lsu_*            LSU read/write request, grant, and response
//   o_ram_*/i_ram_*            RAM command (held in BUSY), ack, and read data
//   o_busy                     high whenever a transaction is in flight
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ram_arb #(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic                    i_ifu_req,
  input  logic [ADDR_WIDTH-1:0]   i_ifu_addr,
  output logic                    o_ifu_gnt,
  output logic                    o_ifu_rvalid,
  output logic [DATA_WIDTH-1:0]   o_ifu_rdata,
  input  logic                    i_lsu_req,
  input  logic                    i_lsu_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_addr,
  input  logic [DATA_WIDTH-1:0]   i_lsu_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_lsu_wr_mask,
  output logic                    o_lsu_gnt,
  output logic                    o_lsu_rvalid,
  output logic [DATA_WIDTH-1:0]   o_lsu_rdata,
  output logic                    o_ram_req,
  output logic                    o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_ram_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_ram_wr_mask,
  input  logic                    i_ram_ack,
  input  logic [DATA_WIDTH-1:0]   i_ram_rd_data,
  output logic                    o_busy
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_LSU, OWN_IFU} owner_t;

  state_t                  state_q, state_d;
  owner_t                  owner_q, owner_d;
  logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic                    cmd_wr_en_q, cmd_wr_en_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0]   cmd_wr_data_q, cmd_wr_data_d;
  logic [MASK_W-1:0]       cmd_wr_mask_q, cmd_wr_mask_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    pick_ifu;
  logic                    ifu_gnt;
  logic                    lsu_gnt;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    starve_cnt_d  = starve_cnt_q;
    cmd_wr_en_d   = cmd_wr_en_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wr_data_d = cmd_wr_data_q;
    cmd_wr_mask_d = cmd_wr_mask_q;
    rdata_d       = rdata_q;
    ifu_gnt       = 1'b0;
    lsu_gnt       = 1'b0;
    // The IFU wins only when it is alone or has waited through STARVE_LIMIT LSU grants.
    pick_ifu      = i_ifu_req && (!i_lsu_req || (starve_cnt_q == CNT_MAX));

    unique case (state_q)
      IDLE: begin
        // Gate on reset so no grant leaks out while reset is held with requests pending.
        if (!i_sys_rst && (i_ifu_req || i_lsu_req)) begin
          state_d = BUSY;
          if (pick_ifu) begin
            ifu_gnt       = 1'b1;
            owner_d       = OWN_IFU;
            cmd_wr_en_d   = 1'b0;
            cmd_addr_d    = i_ifu_addr;
            cmd_wr_data_d = '0;
            cmd_wr_mask_d = '0;
            starve_cnt_d  = '0;
          end else begin
            lsu_gnt       = 1'b1;
            owner_d       = OWN_LSU;
            cmd_wr_en_d   = i_lsu_wr_en;
            cmd_addr_d    = i_lsu_addr;
            cmd_wr_data_d = i_lsu_wr_data;
            cmd_wr_mask_d = i_lsu_wr_mask;
            if (i_ifu_req && (starve_cnt_q != CNT_MAX)) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
          end
        end
      end
      BUSY: begin
        if (i_ram_ack) begin
          // A write completion returns zero data.
          rdata_d = cmd_wr_en_q ? '0 : i_ram_rd_data;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_LSU;
      starve_cnt_q  <= '0;
      cmd_wr_en_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wr_data_q <= '0;
      cmd_wr_mask_q <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      starve_cnt_q  <= starve_cnt_d;
      cmd_wr_en_q   <= cmd_wr_en_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wr_data_q <= cmd_wr_data_d;
      cmd_wr_mask_q <= cmd_wr_mask_d;
      rdata_q       <= rdata_d;
    end
  end

  // Outputs decode registered state so they drop in the same cycle reset asserts.
  logic in_busy;
  logic ifu_resp;
  logic lsu_resp;

  assign in_busy       = (state_q == BUSY);
  assign ifu_resp      = (state_q == RESP) && (owner_q == OWN_IFU);
  assign lsu_resp      = (state_q == RESP) && (owner_q == OWN_LSU);

  assign o_ifu_gnt     = ifu_gnt;
  assign o_lsu_gnt     = lsu_gnt;
  assign o_ram_req     = in_busy;
  assign o_ram_wr_en   = in_busy && cmd_wr_en_q;
  assign o_ram_addr    = in_busy ? cmd_addr_q    : '0;
  assign o_ram_wr_data = in_busy ? cmd_wr_data_q : '0;
  assign o_ram_wr_mask = in_busy ? cmd_wr_mask_q : '0;
  assign o_ifu_rvalid  = ifu_resp;
  assign o_ifu_rdata   = ifu_resp ? rdata_q : '0;
  assign o_lsu_rvalid  = lsu_resp;
  assign o_lsu_rdata   = lsu_resp ? rdata_q : '0;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req;
  logic [AW-1:0] ifu_addr;
  logic          ifu_gnt, ifu_rvalid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req, lsu_wr_en;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wr_data;
  logic [3:0]    lsu_wr_mask;
  logic          lsu_gnt, lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          ram_req, ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [3:0]    ram_wr_mask;
  logic          ram_ack;
  logic [DW-1:0] ram_rd_data;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_ifu_req(ifu_req), .i_ifu_addr(ifu_addr),
    .o_ifu_gnt(ifu_gnt), .o_ifu_rvalid(ifu_rvalid), .o_ifu_rdata(ifu_rdata),
    .i_lsu_req(lsu_req), .i_lsu_wr_en(lsu_wr_en), .i_lsu_addr(lsu_addr),
    .i_lsu_wr_data(lsu_wr_data), .i_lsu_wr_mask(lsu_wr_mask),
    .o_lsu_gnt(lsu_gnt), .o_lsu_rvalid(lsu_rvalid), .o_lsu_rdata(lsu_rdata),
    .o_ram_req(ram_req), .o_ram_wr_en(ram_wr_en), .o_ram_addr(ram_addr),
    .o_ram_wr_data(ram_wr_data), .o_ram_wr_mask(ram_wr_mask),
    .i_ram_ack(ram_ack), .i_ram_rd_data(ram_rd_data),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req = 0; ifu_addr = '0;
    lsu_req = 0; lsu_wr_en = 0; lsu_addr = '0; lsu_wr_data = '0; lsu_wr_mask = '0;
    ram_ack = 0; ram_rd_data = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ram_req"}, 64'(ram_req), 0);
    chk({tag, "_ifu_rv"},  64'(ifu_rvalid), 0);
    chk({tag, "_lsu_rv"},  64'(lsu_rvalid), 0);
    chk({tag, "_busy"},    64'(busy), 0);
  endtask

  logic exp_ifu [6] = '{0, 0, 0, 0, 1, 0};
  logic [2:0] exp_cnt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

  initial begin
    idle_inputs();
    rst = 1;
    #3;
    chk("rst_ram_req", 64'(ram_req), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_gnt", 64'({ifu_gnt, lsu_gnt}), 0);
    tick(); tick();
    rst = 0;

    // IFU-only read, ack two cycles after o_ram_req
    ifu_req = 1; ifu_addr = 32'h8000_0000;
    settle();
    chk("ifu_gnt_T", 64'(ifu_gnt), 1);
    chk("ifu_lsu_gnt_T", 64'(lsu_gnt), 0);
    tick(); ifu_req = 0; ifu_addr = '0; settle();
    chk("ifu_ram_req_T1", 64'(ram_req), 1);
    chk("ifu_ram_addr", 64'(ram_addr), 64'h8000_0000);
    chk("ifu_ram_wr", 64'({ram_wr_en, ram_wr_mask}), 0);
    chk("ifu_busy", 64'(busy), 1);
    tick(); settle();
    chk("ifu_ram_req_T2", 64'(ram_req), 1);
    tick(); ram_ack = 1; ram_rd_data = 32'h1234_5678; settle();
    chk("ifu_rv_T3", 64'(ifu_rvalid), 0);
    tick(); ram_ack = 0; ram_rd_data = '0; settle();
    chk("ifu_rv_T4", 64'(ifu_rvalid), 1);
    chk("ifu_rdata", 64'(ifu_rdata), 64'h1234_5678);
    chk("ifu_lsu_rv", 64'({lsu_rvalid, lsu_rdata}), 0);
    chk("ifu_ram_req_resp", 64'(ram_req), 0);
    tick(); settle();
    chk_quiet("ifu_after");

    // LSU write, ack at once, with a stray ack held into RESP and IDLE
    lsu_req = 1; lsu_wr_en = 1; lsu_addr = 32'h100; lsu_wr_data = 32'hDEAD_BEEF; lsu_wr_mask = 4'h0F;
    settle();
    chk("lsu_gnt_T", 64'(lsu_gnt), 1);
    chk("lsu_ifu_gnt_T", 64'(ifu_gnt), 0);
    tick(); idle_inputs(); ram_ack = 1; ram_rd_data = 32'hAAAA_5555; settle();
    chk("lsu_ram_req", 64'(ram_req), 1);
    chk("lsu_ram_wr_en", 64'(ram_wr_en), 1);
    chk("lsu_ram_mask", 64'(ram_wr_mask), 64'h0F);
    chk("lsu_ram_addr", 64'(ram_addr), 64'h100);
    chk("lsu_ram_wdata", 64'(ram_wr_data), 64'hDEAD_BEEF);
    tick(); settle();
    chk("lsu_rv_T2", 64'(lsu_rvalid), 1);
    chk("lsu_rdata_wr", 64'(lsu_rdata), 0);
    chk("lsu_ifu_rv", 64'(ifu_rvalid), 0);
    tick(); settle();
    chk_quiet("spur_resp");
    tick(); settle();
    chk_quiet("spur_idle");
    chk("spur_starve", 64'(dut.starve_cnt_q), 0);
    ram_ack = 0; ram_rd_data = '0;

    // Both requesting continuously: LSU x4, then IFU, then LSU
    ifu_req = 1; ifu_addr = 32'h300;
    lsu_req = 1; lsu_wr_en = 0; lsu_addr = 32'h200;
    for (int g = 0; g < 6; g++) begin
      settle();
      chk($sformatf("arb%0d_ifu_gnt", g), 64'(ifu_gnt), 64'(exp_ifu[g]));
      chk($sformatf("arb%0d_lsu_gnt", g), 64'(lsu_gnt), 64'(!exp_ifu[g]));
      tick(); ram_ack = 1; ram_rd_data = 32'h0000_0100 + g; settle();
      chk($sformatf("arb%0d_addr", g), 64'(ram_addr), exp_ifu[g] ? 64'h300 : 64'h200);
      chk($sformatf("arb%0d_starve", g), 64'(dut.starve_cnt_q), 64'(exp_cnt[g]));
      chk($sformatf("arb%0d_no_gnt_busy", g), 64'({ifu_gnt, lsu_gnt}), 0);
      tick(); ram_ack = 0; settle();
      chk($sformatf("arb%0d_rv", g), 64'({ifu_rvalid, lsu_rvalid}), exp_ifu[g] ? 64'b10 : 64'b01);
      chk($sformatf("arb%0d_no_gnt_resp", g), 64'({ifu_gnt, lsu_gnt}), 0);
      tick();
    end
    idle_inputs();

    // Reset mid-BUSY with ack still pending
    lsu_req = 1; lsu_addr = 32'h40;
    settle();
    chk("rstb_gnt", 64'(lsu_gnt), 1);
    tick(); ifu_req = 1; ifu_addr = 32'h50; settle();
    chk("rstb_busy_pre", 64'(ram_req), 1);
    rst = 1;
    settle();
    chk("rstb_ram_req", 64'(ram_req), 0);
    chk("rstb_ram_addr", 64'(ram_addr), 0);
    chk("rstb_busy", 64'(busy), 0);
    chk("rstb_gnt_held", 64'({ifu_gnt, lsu_gnt}), 0);
    chk("rstb_starve", 64'(dut.starve_cnt_q), 0);
    tick(); idle_inputs(); rst = 0; ram_ack = 1; ram_rd_data = 32'hBAD0_BAD0; settle();
    chk_quiet("rstb_post0");
    tick(); settle();
    chk_quiet("rstb_post1");
    ram_ack = 0; ram_rd_data = '0;
    ifu_req = 1; ifu_addr = 32'h60;
    settle();
    chk("rstb_fresh_gnt", 64'(ifu_gnt), 1);
    tick(); idle_inputs(); ram_ack = 1; ram_rd_data = 32'hCAFE_F00D; settle();
    chk("rstb_fresh_addr", 64'(ram_addr), 64'h60);
    tick(); ram_ack = 0; settle();
    chk("rstb_fresh_rv", 64'(ifu_rvalid), 1);
    chk("rstb_fresh_rdata", 64'(ifu_rdata), 64'hCAFE_F00D);
    tick();

    // RAM command held stable over a 10-cycle ack delay while requesters wiggle
    lsu_req = 1; lsu_wr_en = 1; lsu_addr = 32'h44; lsu_wr_data = 32'h0102_0304; lsu_wr_mask = 4'h3;
    settle();
    chk("hold_gnt", 64'(lsu_gnt), 1);
    for (int c = 0; c < 10; c++) begin
      tick();
      lsu_wr_en = c[0]; lsu_addr = 32'h1000 + c; lsu_wr_data = 32'hFFFF_0000 | c; lsu_wr_mask = 4'(c);
      ifu_req = 1; ifu_addr = 32'h2000 + c;
      settle();
      chk($sformatf("hold%0d_cmd", c), {ram_req, ram_wr_en, 26'd0, ram_wr_mask, ram_addr[15:0], ram_wr_data[15:0]},
          {1'b1, 1'b1, 26'd0, 4'h3, 16'h0044, 16'h0304});
      chk($sformatf("hold%0d_wdata_hi", c), 64'(ram_wr_data[31:16]), 64'h0102);
      chk($sformatf("hold%0d_no_gnt", c), 64'({ifu_gnt, lsu_gnt}), 0);
    end
    tick(); idle_inputs(); ram_ack = 1; settle();
    chk("hold_ack_cmd", 64'(ram_addr), 64'h44);
    tick(); ram_ack = 0; settle();
    chk("hold_rv", 64'({lsu_rvalid, lsu_rdata}), 64'h1_0000_0000);
    tick(); settle();
    chk_quiet("hold_end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
